// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the alu_sched block: opcode encoding, FSM
// states and multiply sequencing length.
package alu_sched_pkg;

  localparam int ALU_WIDTH  = 4;
  localparam int MUL_CYCLES = 2 * ALU_WIDTH;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_MUL  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ADD  = 3'b110,
    OP_SUB  = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_MUL_ADD = 3'd2,
    S_MUL_SHL = 3'd3,
    S_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from req, searching from the
// requester after the last one granted; the pointer moves only on advance.
module rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] last;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    pick  = last;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        pick        = cand;
        found       = 1'b1;
      end
    end
  end

  // After reset the pointer sits on the last requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= IW'(NREQ - 1);
    end else if (advance && found) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one external ALU between NREQ requesters, one op in flight, and
// sequences shift/add multiplies when ALU_SCHED_MUL_EN is defined.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][2:0]       req_op,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  output logic [NREQ-1:0]            resp_valid,
  input  logic [NREQ-1:0]            resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic                       resp_err,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [2:0]                 alu_cntl,
  input  logic [WIDTH-1:0]           alu_result,
  output state_t                     fsm_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready; valid never
  // waits for ready, and response data/err hold steady while valid is high.

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, next_state;
  logic [NREQ-1:0]   grant;
  logic              accept;
  op_t               sel_op, op_q;
  logic [WIDTH-1:0]  sel_a, sel_b, a_q, b_q;
  logic [IW-1:0]     sel_idx, owner_q;

`ifdef ALU_SCHED_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] acc, mc, mp;
  logic [CW-1:0]    cnt;
`endif

  rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    sel_op  = OP_PASS;
    sel_a   = '0;
    sel_b   = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op  = op_t'(req_op[i]);
        sel_a   = req_a[i];
        sel_b   = req_b[i];
        sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    next_state = state;
    alu_a      = '0;
    alu_b      = '0;
    alu_cntl   = OP_PASS;
    case (state)
      S_IDLE: begin
        req_ready = grant;
        accept    = |(req_valid & grant);
        if (accept) begin
`ifdef ALU_SCHED_MUL_EN
          next_state = (sel_op == OP_MUL) ? S_MUL_ADD : S_EXEC;
`else
          next_state = (sel_op == OP_MUL) ? S_RESP : S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_cntl   = op_q;
        next_state = S_RESP;
      end
`ifdef ALU_SCHED_MUL_EN
      S_MUL_ADD: begin
        alu_a      = acc;
        alu_b      = mc;
        alu_cntl   = mp[0] ? OP_ADD : OP_PASS;
        next_state = S_MUL_SHL;
      end
      S_MUL_SHL: begin
        alu_a      = mc;
        alu_cntl   = OP_SHL;
        next_state = (cnt == CNT_LAST) ? S_RESP : S_MUL_ADD;
      end
`endif
      S_RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      resp_data <= '0;
      resp_err  <= 1'b0;
      op_q      <= OP_PASS;
      a_q       <= '0;
      b_q       <= '0;
      owner_q   <= '0;
`ifdef ALU_SCHED_MUL_EN
      acc       <= '0;
      mc        <= '0;
      mp        <= '0;
      cnt       <= '0;
`endif
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            owner_q <= sel_idx;
`ifdef ALU_SCHED_MUL_EN
            acc     <= '0;
            mc      <= sel_a;
            mp      <= sel_b;
            cnt     <= '0;
`else
            if (sel_op == OP_MUL) begin
              resp_data <= '0;
              resp_err  <= 1'b1;
            end
`endif
          end
        end
        S_EXEC: begin
          resp_data <= alu_result;
          resp_err  <= 1'b0;
        end
`ifdef ALU_SCHED_MUL_EN
        S_MUL_ADD: acc <= alu_result;
        // acc already holds the final partial sum when the last shift runs.
        S_MUL_SHL: begin
          mc <= alu_result;
          mp <= mp >> 1;
          if (cnt == CNT_LAST) begin
            resp_data <= acc;
            resp_err  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
Shares one 4-bit alu instance between NREQ requesters using round-robin arbitration, with one operation in flight at a time.
- Each requester issues (op, a, b) on a valid/ready handshake and receives a registered result on a valid/ready response channel.
- The block also sequences the ALU to build a multi-cycle multiply (opcode 3'b001, undecoded by the ALU) from repeated pass/add/shift steps.
- Sits between the datapath front-end requesters and the alu module; it drives the ALU's a, b and cntl inputs.

Parameters:
NREQ, 2, number of requesters (fixed at 2 for this revision; arbiter written generically).
WIDTH, 4, operand/result width; must match the ALU.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  [NREQ-1:0]  request present, per requester
req_ready  output  [NREQ-1:0]  request accepted this cycle
req_op  input  [NREQ-1:0][2:0]  opcode, ALU encoding plus 3'b001 = MUL
req_a  input  [NREQ-1:0][WIDTH-1:0]  operand a
req_b  input  [NREQ-1:0][WIDTH-1:0]  operand b
resp_valid  output  [NREQ-1:0]  result valid for requester i
resp_ready  input  [NREQ-1:0]  requester consumes result
resp_data  output  WIDTH  result, shared bus, qualified by resp_valid
resp_err  output  1  illegal-op flag, qualified by resp_valid
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_cntl  output  3  to ALU cntl; never 3'b001
alu_result  input  WIDTH  from ALU result (combinational)

Behaviour:
- States: IDLE, EXEC, MUL_ADD, MUL_SHL, RESP.
- Reset (any state, including mid-MUL or mid-RESP):
  - state=IDLE; req_ready=0; resp_valid=0; resp_data=0; resp_err=0.
  - Round-robin pointer favours requester 0; the in-flight op is dropped.
- IDLE arbitration:
  - Grant is combinational from req_valid. req_ready[g]=1 only for the granted requester.
  - Two requesters contending: grant the one not granted last. Single requester: grant it.
  - req_valid must not depend on req_ready.
  - Accept on req_valid[g]&&req_ready[g]: latch op, a, b and owner; update the pointer.
  - Next state: MUL if op==001, else EXEC.
- EXEC (one cycle): alu_a=a, alu_b=b, alu_cntl=op; register alu_result into resp_data; go to RESP.
- MUL: result = a*b mod 2^WIDTH, built from registers acc=0, mc=a, mp=b, cnt=0.
  - MUL_ADD: alu_a=acc, alu_b=mc; alu_cntl=3'b110 if mp[0], else 3'b000. acc<=alu_result.
  - MUL_SHL: alu_a=mc, alu_cntl=3'b100; mc<=alu_result; mp<=mp>>1.
  - After MUL_SHL: if cnt==WIDTH-1 go to RESP with resp_data=acc; else cnt++ and return to MUL_ADD.
  - Fixed 2*WIDTH ALU cycles; no early exit.
- RESP:
  - resp_valid[owner]=1; resp_data and resp_err held stable until resp_ready[owner].
  - On that cycle, go to IDLE and drop resp_valid. No new grant in the same cycle.
  - resp_ready of non-owners is ignored.
- Latency from the accept cycle N:
  - Single op: resp_valid rises in cycle N+2.
  - MUL: resp_valid rises in cycle N+1+2*WIDTH (N+9 at WIDTH=4).
  - Minimum spacing between accepts: 3 cycles.
- Arithmetic:
  - All results are WIDTH bits; overflow and borrow wrap silently.
  - Shifts are logical (operands unsigned): 4'b1001 SHL gives 4'b0010.
- Idle ALU drive: outside EXEC/MUL states, alu_a=0, alu_b=0, alu_cntl=3'b000, so the ALU never sees an undecoded cntl.

Optional Feature:
ALU_SCHED_MUL_EN
- Defined: MUL sequencing as above; resp_err is always 0.
- Undefined: MUL_ADD/MUL_SHL are not built. Opcode 001 goes IDLE→RESP directly with resp_data=0 and resp_err=1; the ALU is not driven.

Decomposition:
- Package alu_sched_pkg:
  - Opcode enum: OP_PASS=000, OP_MUL=001, OP_AND=010, OP_OR=011, OP_SHL=100, OP_SHR=101, OP_ADD=110, OP_SUB=111.
  - State enum.
  - Localparam MUL_CYCLES=2*WIDTH.
- Sub-module rr_arb: round-robin arbiter (NREQ, req vector, advance strobe, one-hot grant, registered pointer, same clk/reset).
- alu_sched instantiates rr_arb. The alu is instantiated beside it by the parent.

Test Plan:
- Req0 ADD a=9, b=8 after reset → req_ready[0]=1 in cycle N; resp_valid[0] at N+2; resp_data=4'h1; resp_err=0.
- Req0 SUB a=2, b=5; resp_ready held low 4 cycles → resp_valid[0] and resp_data=4'hD held stable throughout; req_ready stays 0 until consumed.
- Both requesters valid continuously with AND ops → grants alternate 0,1,0,1; first grant goes to 0 after reset; accepts spaced exactly 3 cycles.
- MUL_EN defined:
  - Req1 MUL a=7, b=6 → alu_cntl sequence 000,100,110,100,110,100,000,100; resp_data=4'hA at N+9.
  - 3×5 → 4'hF.
- MUL_EN undefined: MUL a=3, b=3 → resp_err=1, resp_data=0, alu_cntl stays 000.
- Reset asserted in MUL_ADD of a MUL → next cycle state IDLE, resp_valid=0; a subsequent request completes normally, with requester 0 prioritised.
